// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    // Address width for a register file of the given depth; never below 1 bit.
    function automatic int adr_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    localparam int DEFAULT_REGISTER_COUNT = 32;
    localparam int DEFAULT_AW             = adr_width(DEFAULT_REGISTER_COUNT);

    typedef logic [DEFAULT_AW-1:0] regAdr_t;

    // Architectural zero register.
    localparam regAdr_t ZERO_ADR = '0;

endpackage

// File: rtl/flopRE.sv
// Word-wide storage flop with enable and synchronous active-low reset.
// Latency: one clock from d/en to q.
// Backpressure: none; q holds while en is low.
module flopRE #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable; reset clears the stored word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_scoreboard.sv
// Pending-write scoreboard: reservations, per-source readiness, issue stall, error flag.
// Latency: readiness and stall are combinational; reservations update on the clock edge.
// Backpressure: stall blocks issue on RAW (source pending) or WAW (destination pending).
module register_scoreboard
    import regfile_pkg::*;
#(
    parameter int REGISTER_COUNT = 32,
    parameter int READ_PORTS     = 2,
    parameter int ZERO_REG       = 1,
    parameter int AW             = $clog2(REGISTER_COUNT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [READ_PORTS-1:0][AW-1:0] rs_adr,
    input  logic                          issue_valid,
    input  logic                          issue_uses_rd,
    input  logic [AW-1:0]                 issue_rd_adr,
    input  logic                          wb_valid,
    input  logic [AW-1:0]                 wb_rd_adr,
    output logic [READ_PORTS-1:0]         rs_ready,
    output logic                          stall,
    output logic [AW:0]                   pending_count,
    output logic                          wb_error
);

    logic [REGISTER_COUNT-1:0] pending;
    logic [REGISTER_COUNT-1:0] pending_nxt;
    logic                      rd_free;
    logic                      set_en;
    logic                      clr_en;
    logic                      clr_same;
    logic                      inc;
    logic                      dec;
    logic [AW:0]               count_nxt;
    logic                      error_nxt;

    function automatic logic is_zero(input logic [AW-1:0] adr);
        return (ZERO_REG != 0) && (adr == AW'(ZERO_ADR));
    endfunction

    // Source readiness: not reserved, or the writeback this cycle produces it.
    always_comb begin
        rs_ready = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rs_ready[p] = is_zero(rs_adr[p]) || !pending[rs_adr[p]] ||
                          (wb_valid && (wb_rd_adr == rs_adr[p]));
        end
    end

    // Hazard detection and next scoreboard state; a same-cycle set beats a clear.
    always_comb begin
        rd_free     = is_zero(issue_rd_adr) || !pending[issue_rd_adr] ||
                      (wb_valid && (wb_rd_adr == issue_rd_adr));
        stall       = issue_valid && (!(&rs_ready) || (issue_uses_rd && !rd_free));
        set_en      = issue_valid && !stall && issue_uses_rd && !is_zero(issue_rd_adr);
        clr_en      = wb_valid && !is_zero(wb_rd_adr);
        clr_same    = clr_en && (wb_rd_adr == issue_rd_adr);
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[wb_rd_adr] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[issue_rd_adr] = 1'b1;
        end
        // A set only adds to the count when the bit is not already held going forward.
        inc       = set_en && !(pending[issue_rd_adr] && !clr_same);
        dec       = clr_en && pending[wb_rd_adr];
        count_nxt = pending_count + (AW+1)'(inc) - (AW+1)'(dec);
        error_nxt = wb_error || (clr_en && !pending[wb_rd_adr]);
    end

    // Scoreboard state; reset drops every reservation without writebacks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending       <= '0;
            pending_count <= '0;
            wb_error      <= 1'b0;
        end else begin
            pending       <= pending_nxt;
            pending_count <= count_nxt;
            wb_error      <= error_nxt;
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-read-port register file with pending-write scoreboard and writeback bypass.
// Latency: reads are combinational (0 cycles) with same-cycle wb_data bypass; writes land on the edge.
// Backpressure: stall holds decode when a source or the destination has an outstanding write.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int REGISTER_COUNT = 32,
    parameter int READ_PORTS     = 2,
    parameter int ZERO_REG       = 1,
    parameter int AW             = $clog2(REGISTER_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [READ_PORTS-1:0][AW-1:0]        rs_adr,
    output logic [READ_PORTS-1:0][WORD_SIZE-1:0] rs_data,
    output logic [READ_PORTS-1:0]                rs_ready,
    input  logic                                 issue_valid,
    input  logic                                 issue_uses_rd,
    input  logic [AW-1:0]                        issue_rd_adr,
    output logic                                 stall,
    input  logic                                 wb_valid,
    input  logic [AW-1:0]                        wb_rd_adr,
    input  logic [WORD_SIZE-1:0]                 wb_data,
    output logic [AW:0]                          pending_count,
    output logic                                 wb_error
);

    logic [WORD_SIZE-1:0]      regs [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] wr_en;

    // Per-register write enable; the zero register never loads when hardwired.
    always_comb begin
        wr_en = '0;
        for (int i = 0; i < REGISTER_COUNT; i++) begin
            wr_en[i] = wb_valid && (wb_rd_adr == AW'(i)) && !((ZERO_REG != 0) && (i == 0));
        end
    end

    for (genvar i = 0; i < REGISTER_COUNT; i++) begin : g_reg
        flopRE #(.WIDTH(WORD_SIZE)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (wr_en[i]),
            .d     (wb_data),
            .q     (regs[i])
        );
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        // Read mux: hardwired zero first, then writeback bypass, then storage.
        always_comb begin
            if ((ZERO_REG != 0) && (rs_adr[p] == AW'(ZERO_ADR))) begin
                rs_data[p] = '0;
            end else if (wb_valid && (wb_rd_adr == rs_adr[p])) begin
                rs_data[p] = wb_data;
            end else begin
                rs_data[p] = regs[rs_adr[p]];
            end
        end
    end

    register_scoreboard #(
        .REGISTER_COUNT (REGISTER_COUNT),
        .READ_PORTS     (READ_PORTS),
        .ZERO_REG       (ZERO_REG),
        .AW             (AW)
    ) u_sb (
        .clk           (clk),
        .reset         (reset),
        .rs_adr        (rs_adr),
        .issue_valid   (issue_valid),
        .issue_uses_rd (issue_uses_rd),
        .issue_rd_adr  (issue_rd_adr),
        .wb_valid      (wb_valid),
        .wb_rd_adr     (wb_rd_adr),
        .rs_ready      (rs_ready),
        .stall         (stall),
        .pending_count (pending_count),
        .wb_error      (wb_error)
    );

endmodule
